// File: rtl/fetch_ex_pipe_ctrl_pkg.sv
// Shared encodings for the IF->EX pipeline controller: PC select codes,
// controller FSM states and the bubble instruction.
package fetch_ex_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_SEL_RESET = 2'd0,
    PC_SEL_HOLD  = 2'd1,
    PC_SEL_PC4   = 2'd2,
    PC_SEL_ALU   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_ex_pipe_ctrl_perf_counters.sv
// Cycle and retired-instruction counters, clearable from the CSR path.
// A clear always wins over a simultaneous increment.
module perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_cycle,
  input  logic             inc_ret,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (clr) begin
      cycle_d   = '0;
      instret_d = '0;
    end else begin
      if (inc_cycle) cycle_d   = cycle_q + ONE;
      if (inc_ret)   instret_d = instret_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/fetch_ex_pipe_ctrl.sv
// IF->EX pipeline register and fetch controller: drives the IF PC select and
// flush, captures the fetched instruction into EX, and hosts the perf counters.
module fetch_ex_pipe_ctrl
  import fetch_ex_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INST,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             cnt_clr,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic [1:0]       pc_sel,
  output logic             should_br,
  output logic [31:0]      ex_inst,
  output logic [31:0]      ex_pc,
  output logic             ex_valid,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e      state_q;
  logic [31:0] ex_inst_q;
  logic [31:0] ex_pc_q;
  logic        ex_valid_q;
  pc_sel_e     pc_sel_d;
  logic        should_br_d;

  // Priority: reset > boot > stall > taken branch > sequential advance.
  always_comb begin
    pc_sel_d    = PC_SEL_PC4;
    should_br_d = 1'b0;
    if (rst || state_q == ST_BOOT) begin
      pc_sel_d = PC_SEL_RESET;
    end else if (stall) begin
      pc_sel_d = PC_SEL_HOLD;
    end else if (br_taken) begin
      pc_sel_d    = PC_SEL_ALU;
      should_br_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      ex_inst_q  <= NOP;
      ex_pc_q    <= RESET_PC;
      ex_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          ex_inst_q  <= NOP;
          ex_valid_q <= 1'b0;
          state_q    <= ST_RUN;
        end
        default: begin
          // HOLD without stall advances exactly like RUN.
          if (stall) begin
            state_q <= ST_HOLD;
          end else begin
            state_q <= ST_RUN;
            ex_pc_q <= if_pc;
            if (br_taken) begin
              ex_inst_q  <= NOP;
              ex_valid_q <= 1'b0;
            end else begin
              ex_inst_q  <= if_inst;
              ex_valid_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .inc_cycle  (state_q != ST_BOOT),
    .inc_ret    (ex_valid_q && !stall),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  assign pc_sel    = pc_sel_d;
  assign should_br = should_br_d;
  assign ex_inst   = ex_inst_q;
  assign ex_pc     = ex_pc_q;
  assign ex_valid  = ex_valid_q;

endmodule
